cpu_decode: RTL and testbench
=============================

CPU_DECODE -- requirements
Module: cpu_decode

Interface
REQ-001 Parameter TAG_W, default 8, width of every tag port; taken from the shared defines.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset: i_clock in 1, rising-edge clock; i_reset in 1, synchronous active-high reset.
REQ-003 Fetch side ports SHALL be:
- i_fetch_tag in TAG_W: new instruction when it differs from the last accepted value.
- i_fetch_instruction in 32.
- i_fetch_pc in 32.
REQ-004 Register-file read side ports SHALL be:
- o_read_tag out TAG_W.
- o_read_rs1_idx out 5.
- o_read_rs2_idx out 5.
REQ-005 Writeback observation ports SHALL be:
- i_wb_tag in TAG_W: changes once per register write.
- i_wb_rd_idx in 5.
REQ-006 Execute side ports SHALL be:
- i_execute_busy in 1.
- i_flush in 1.
- o_tag out TAG_W.
- o_pc out 32.
- o_instruction out 32.
- o_rd_idx out 5.
- o_imm out 32.
- o_writes_rd out 1.
- o_illegal out 1.
- o_stalled out 1: high in WAIT_HAZARD.

Function
REQ-007 A fetch is accepted only in IDLE when i_fetch_tag != last_fetch_tag; accepting SHALL latch instruction, pc and i_fetch_tag.
REQ-008 States SHALL be IDLE, WAIT_HAZARD and ISSUE; all transitions occur on the rising edge.
REQ-009 The block SHALL decode the rs1, rs2 and rd fields and an rs1_used/rs2_used/writes_rd flag from the RV32I opcode.
REQ-010 Immediate decode SHALL follow the RV32I I/S/B/U/J formats, sign-extended to 32 bits; R-type yields 0.
REQ-011 An unknown opcode SHALL set o_illegal=1, writes_rd=0 and no operands used, and SHALL still issue.
REQ-012 Hazard = (rs1_used && rs1!=0 && busy[rs1]) || (rs2_used && rs2!=0 && busy[rs2]), evaluated against the scoreboard after the same-cycle writeback clear.
REQ-013 In IDLE, on accept:
- With a hazard: go to WAIT_HAZARD.
- With no hazard: drive o_read_rs1/rs2_idx, increment o_read_tag (mod 2^TAG_W) and go to ISSUE.
REQ-014 In WAIT_HAZARD, re-evaluate the hazard every cycle; when it is clear, increment o_read_tag and go to ISSUE.
REQ-015 In ISSUE, when i_execute_busy=0, the block SHALL:
- Update all execute outputs.
- Increment o_tag.
- Set busy[rd] if writes_rd && rd!=0.
- Go to IDLE.
When i_execute_busy=1, remain in ISSUE with outputs held.
REQ-016 Latency SHALL be: fetch tag change seen in IDLE at edge E0, o_read_tag at E0, o_tag at E1 at the earliest; sustained throughput is one instruction per 2 cycles.
REQ-017 o_read_rs*_idx SHALL stay stable from the o_read_tag increment until the o_tag increment.
REQ-018 Scoreboard is busy[31:0], with busy[0] always 0; on i_wb_tag != last_wb_tag it SHALL clear busy[i_wb_rd_idx] and latch last_wb_tag.
REQ-019 If set and clear target the same register in the same cycle, set SHALL win.
REQ-020 i_flush=1 SHALL force IDLE, drop any latched or pending instruction and leave o_tag unchanged; last_fetch_tag SHALL be set to the current i_fetch_tag.
REQ-021 The scoreboard SHALL be unaffected by flush.
REQ-022 Tag counters SHALL wrap modulo 2^TAG_W; only the tag change is significant.

Reset
REQ-023 i_reset SHALL:
- Force IDLE.
- Zero all outputs, busy and last_wb_tag.
- Load last_fetch_tag from i_fetch_tag, so no spurious accept follows reset.
REQ-024 Reset SHALL take priority over flush and all handshakes; a reset mid-ISSUE SHALL discard the instruction.

Structure
REQ-025 The opcode constants, the TAG_W/TAG_SIZE define and the state encoding SHALL reside in the shared defines file.
REQ-026 One combinational sub-module, cpu_decode_imm, SHALL produce the immediate, the field flags and the illegal flag; the state machine and scoreboard stay in cpu_decode.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- addi x5,x0,7 (0x00700293) after fetch tag 0->1: o_read_tag 0->1 next edge, o_tag 0->1 one edge later, o_imm=7, o_rd_idx=5, busy[5]=1.
- add x6,x5,x5 while busy[5]=1: o_stalled=1, no o_read_tag change; wb tag change with rd=5 -> busy[5] clears, then issue proceeds.
- i_execute_busy=1 for 3 cycles in ISSUE: o_tag unchanged for 3 cycles, then increments exactly once.
- Writeback clear of x7 and issue of a new write to x7 in the same cycle: busy[7]=1 afterwards.
- Flush in WAIT_HAZARD: returns to IDLE, o_tag unchanged, the next fetch tag change is decoded normally.
- Opcode 0x0000007F: o_illegal=1, o_writes_rd=0; tag wrap 0xFF->0x00 still issues.

Source files
------------

// File: rtl/cpu_decode_pkg.sv
// Shared defines for the decode stage: tag width, RV32I opcodes, FSM encoding
// and the decoded-field bundle passed from the immediate decoder to the FSM.
// No ports; imported by cpu_decode and cpu_decode_imm.
package cpu_decode_pkg;

  localparam int TAG_W    = 8;
  localparam int TAG_SIZE = 1 << TAG_W;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_HAZARD = 2'd1,
    ST_ISSUE       = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_used;
    logic        rs2_used;
    logic        writes_rd;
    logic        illegal;
    logic [31:0] imm;
  } dec_t;

endpackage

// File: rtl/cpu_decode_imm.sv
// Combinational RV32I field decoder: register indices, operand-use flags,
// sign-extended immediate and illegal-opcode flag.
// Ports: instruction (32-bit word in), dec (decoded bundle out).
module cpu_decode_imm
  import cpu_decode_pkg::*;
(
  input  logic [31:0] instruction,
  output dec_t        dec
);

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  always_comb begin
    dec           = '0;
    dec.rs1       = instruction[19:15];
    dec.rs2       = instruction[24:20];
    dec.rd        = instruction[11:7];
    case (instruction[6:0])
      OPC_LUI, OPC_AUIPC: begin
        dec.writes_rd = 1'b1;
        dec.imm       = imm_u;
      end
      OPC_JAL: begin
        dec.writes_rd = 1'b1;
        dec.imm       = imm_j;
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: begin
        dec.rs1_used  = 1'b1;
        dec.writes_rd = 1'b1;
        dec.imm       = imm_i;
      end
      OPC_BRANCH: begin
        dec.rs1_used  = 1'b1;
        dec.rs2_used  = 1'b1;
        dec.imm       = imm_b;
      end
      OPC_STORE: begin
        dec.rs1_used  = 1'b1;
        dec.rs2_used  = 1'b1;
        dec.imm       = imm_s;
      end
      OPC_OP: begin
        dec.rs1_used  = 1'b1;
        dec.rs2_used  = 1'b1;
        dec.writes_rd = 1'b1;
      end
      OPC_MISC_MEM: begin
        // FENCE carries an I-format word but touches no GPR operands.
        dec.imm       = imm_i;
      end
      default: begin
        // Unknown opcodes still flow to execute so it can raise the trap.
        dec.illegal   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_decode.sv
// Decode stage: accepts tagged fetches, stalls on scoreboard hazards, issues
// decoded instructions to execute and tracks pending register writes.
// Ports: i_clock/i_reset; fetch (tag/instruction/pc in); register-file read
// (o_read_tag/rs1/rs2 out); writeback observe (tag/rd in); execute (busy/flush
// in, tag/pc/instruction/rd/imm/writes_rd/illegal/stalled out).
module cpu_decode
  import cpu_decode_pkg::*;
#(
  parameter int TAG_W = cpu_decode_pkg::TAG_W
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [TAG_W-1:0] i_fetch_tag,
  input  logic [31:0]      i_fetch_instruction,
  input  logic [31:0]      i_fetch_pc,
  output logic [TAG_W-1:0] o_read_tag,
  output logic [4:0]       o_read_rs1_idx,
  output logic [4:0]       o_read_rs2_idx,
  input  logic [TAG_W-1:0] i_wb_tag,
  input  logic [4:0]       i_wb_rd_idx,
  input  logic             i_execute_busy,
  input  logic             i_flush,
  output logic [TAG_W-1:0] o_tag,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_instruction,
  output logic [4:0]       o_rd_idx,
  output logic [31:0]      o_imm,
  output logic             o_writes_rd,
  output logic             o_illegal,
  output logic             o_stalled
);

  state_t           state, state_nxt;
  logic [TAG_W-1:0] last_fetch_tag;
  logic [TAG_W-1:0] last_wb_tag;
  logic [31:0]      lat_instr;
  logic [31:0]      lat_pc;
  logic [31:0]      busy;

  logic [31:0]      cur_instr;
  dec_t             dec;
  logic             accept;
  logic             wb_clr;
  logic [31:0]      clr_mask;
  logic [31:0]      set_mask;
  logic [31:0]      busy_clr;
  logic             hazard;
  logic             issue_go;
  logic             to_issue;

  // In IDLE the hazard check must see the incoming word so accept and the
  // IDLE->ISSUE decision happen on the same edge; afterwards use the latch.
  assign cur_instr = (state == ST_IDLE) ? i_fetch_instruction : lat_instr;

  cpu_decode_imm u_imm (
    .instruction (cur_instr),
    .dec         (dec)
  );

  assign accept   = (state == ST_IDLE) && (i_fetch_tag != last_fetch_tag);
  assign wb_clr   = (i_wb_tag != last_wb_tag);
  assign clr_mask = wb_clr ? (32'd1 << i_wb_rd_idx) : 32'd0;
  // Hazards are judged after this cycle's writeback clear so a dependent
  // instruction can leave WAIT_HAZARD on the very edge the producer retires.
  assign busy_clr = busy & ~clr_mask;
  assign hazard   = (dec.rs1_used && (dec.rs1 != 5'd0) && busy_clr[dec.rs1]) ||
                    (dec.rs2_used && (dec.rs2 != 5'd0) && busy_clr[dec.rs2]);
  assign issue_go = (state == ST_ISSUE) && !i_execute_busy && !i_flush;
  assign to_issue = !i_flush && !hazard &&
                    (accept || (state == ST_WAIT_HAZARD));
  // Set is OR-ed after the clear so it wins on a same-register collision.
  assign set_mask = (issue_go && dec.writes_rd && (dec.rd != 5'd0)) ?
                    (32'd1 << dec.rd) : 32'd0;

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (i_flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:        if (accept) state_nxt = hazard ? ST_WAIT_HAZARD : ST_ISSUE;
        ST_WAIT_HAZARD: if (!hazard) state_nxt = ST_ISSUE;
        ST_ISSUE:       if (!i_execute_busy) state_nxt = ST_IDLE;
        default:        state_nxt = ST_IDLE;
      endcase
    end
  end

  // State-derived outputs
  always_comb begin
    o_stalled = (state == ST_WAIT_HAZARD);
  end

  // Datapath, tag counters and scoreboard
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      last_fetch_tag <= i_fetch_tag;
      last_wb_tag    <= '0;
      lat_instr      <= '0;
      lat_pc         <= '0;
      busy           <= '0;
      o_read_tag     <= '0;
      o_read_rs1_idx <= '0;
      o_read_rs2_idx <= '0;
      o_tag          <= '0;
      o_pc           <= '0;
      o_instruction  <= '0;
      o_rd_idx       <= '0;
      o_imm          <= '0;
      o_writes_rd    <= 1'b0;
      o_illegal      <= 1'b0;
    end else begin
      busy <= (busy_clr | set_mask) & ~32'd1;
      if (wb_clr) last_wb_tag <= i_wb_tag;

      if (i_flush) begin
        // Resync so the tag already on the fetch bus is not replayed.
        last_fetch_tag <= i_fetch_tag;
      end else if (accept) begin
        last_fetch_tag <= i_fetch_tag;
        lat_instr      <= i_fetch_instruction;
        lat_pc         <= i_fetch_pc;
      end

      if (to_issue) begin
        o_read_tag     <= o_read_tag + 1'b1;
        o_read_rs1_idx <= dec.rs1;
        o_read_rs2_idx <= dec.rs2;
      end

      if (issue_go) begin
        o_tag         <= o_tag + 1'b1;
        o_pc          <= lat_pc;
        o_instruction <= lat_instr;
        o_rd_idx      <= dec.rd;
        o_imm         <= dec.imm;
        o_writes_rd   <= dec.writes_rd;
        o_illegal     <= dec.illegal;
      end
    end
  end

endmodule

// File: tb/tb_cpu_decode.sv
// Directed bench for cpu_decode: hand-written multi-cycle scenarios followed
// by a table of single-instruction decode vectors and a tag-wrap run.
module tb_cpu_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  fetch_tag;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic [7:0]  read_tag;
  logic [4:0]  rs1_idx, rs2_idx;
  logic [7:0]  wb_tag;
  logic [4:0]  wb_rd;
  logic        ex_busy;
  logic        flush;
  logic [7:0]  o_tag;
  logic [31:0] o_pc, o_instr, o_imm;
  logic [4:0]  o_rd;
  logic        o_wr, o_ill, o_stall;

  int checks   = 0;
  int failures = 0;

  cpu_decode #(.TAG_W(8)) dut (
    .i_clock             (clk),
    .i_reset             (rst),
    .i_fetch_tag         (fetch_tag),
    .i_fetch_instruction (fetch_instr),
    .i_fetch_pc          (fetch_pc),
    .o_read_tag          (read_tag),
    .o_read_rs1_idx      (rs1_idx),
    .o_read_rs2_idx      (rs2_idx),
    .i_wb_tag            (wb_tag),
    .i_wb_rd_idx         (wb_rd),
    .i_execute_busy      (ex_busy),
    .i_flush             (flush),
    .o_tag               (o_tag),
    .o_pc                (o_pc),
    .o_instruction       (o_instr),
    .o_rd_idx            (o_rd),
    .o_imm               (o_imm),
    .o_writes_rd         (o_wr),
    .o_illegal           (o_ill),
    .o_stalled           (o_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wr;
    logic        ill;
    logic        chk_imm;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fetch(input logic [7:0] tag, input logic [31:0] ins, input logic [31:0] pc);
    fetch_tag   = tag;
    fetch_instr = ins;
    fetch_pc    = pc;
  endtask

  // Bounded wait for o_tag to reach a value.
  task automatic wait_tag(input logic [7:0] exp, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (o_tag === exp) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit         ok;
    logic [7:0] exp_tag;
    logic [7:0] t;

    vt[0] = '{32'hFFF00093, 32'hFFFFFFFF, 5'd1,  1'b1, 1'b0, 1'b1}; // addi x1,x0,-1
    vt[1] = '{32'h12345137, 32'h12345000, 5'd2,  1'b1, 1'b0, 1'b1}; // lui x2,0x12345
    vt[2] = '{32'hFE002E23, 32'hFFFFFFFC, 5'd28, 1'b0, 1'b0, 1'b1}; // sw x0,-4(x0)
    vt[3] = '{32'h00000463, 32'h00000008, 5'd8,  1'b0, 1'b0, 1'b1}; // beq x0,x0,+8
    vt[4] = '{32'hFFDFF0EF, 32'hFFFFFFFC, 5'd1,  1'b1, 1'b0, 1'b1}; // jal x1,-4
    vt[5] = '{32'h80000197, 32'h80000000, 5'd3,  1'b1, 1'b0, 1'b1}; // auipc x3,0x80000
    vt[6] = '{32'h0000007F, 32'h00000000, 5'd0,  1'b0, 1'b1, 1'b0}; // unknown opcode
    vt[7] = '{32'h01002203, 32'h00000010, 5'd4,  1'b1, 1'b0, 1'b1}; // lw x4,16(x0)
    vt[8] = '{32'h000003B3, 32'h00000000, 5'd7,  1'b1, 1'b0, 1'b1}; // add x7,x0,x0

    rst = 1'b1; ex_busy = 1'b0; flush = 1'b0;
    wb_tag = 8'd0; wb_rd = 5'd0;
    fetch(8'd0, 32'h0, 32'h0);
    step(2);
    rst = 1'b0;
    step(1);
    chk("reset_o_tag", o_tag, 0);
    chk("reset_read_tag", read_tag, 0);
    chk("reset_stalled", o_stall, 0);
    chk("reset_imm", o_imm, 0);
    chk("reset_busy", dut.busy, 0);

    // addi x5,x0,7
    fetch(8'd1, 32'h00700293, 32'h100);
    step(1);
    chk("s1_read_tag", read_tag, 1);
    chk("s1_o_tag_not_yet", o_tag, 0);
    step(1);
    chk("s1_o_tag", o_tag, 1);
    chk("s1_imm", o_imm, 7);
    chk("s1_rd", o_rd, 5);
    chk("s1_wr", o_wr, 1);
    chk("s1_pc", o_pc, 32'h100);
    chk("s1_busy5", dut.busy[5], 1);

    // add x6,x5,x5 stalls on x5
    fetch(8'd2, 32'h00528333, 32'h104);
    step(1);
    chk("s2_stalled", o_stall, 1);
    chk("s2_read_tag_held", read_tag, 1);
    step(2);
    chk("s2_still_stalled", o_stall, 1);
    chk("s2_read_tag_held2", read_tag, 1);
    wb_rd = 5'd5; wb_tag = 8'd1;
    step(1);
    chk("s2_unstall", o_stall, 0);
    chk("s2_read_tag", read_tag, 2);
    chk("s2_rs1", rs1_idx, 5);
    chk("s2_rs2", rs2_idx, 5);
    chk("s2_busy5_clear", dut.busy[5], 0);
    step(1);
    chk("s2_o_tag", o_tag, 2);
    chk("s2_rd", o_rd, 6);
    chk("s2_busy6", dut.busy[6], 1);

    // execute busy for three cycles in ISSUE
    ex_busy = 1'b1;
    fetch(8'd3, 32'h00100413, 32'h108);
    step(1);
    chk("s3_read_tag", read_tag, 3);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("s3_o_tag_held", o_tag, 2);
      chk("s3_rd_held", o_rd, 6);
    end
    ex_busy = 1'b0;
    step(1);
    chk("s3_o_tag", o_tag, 3);
    chk("s3_imm", o_imm, 1);
    step(1);
    chk("s3_o_tag_once", o_tag, 3);

    // same-cycle clear and set of x7
    fetch(8'd4, 32'h000003B3, 32'h10C);
    step(2);
    chk("s4_o_tag_a", o_tag, 4);
    chk("s4_busy7_set", dut.busy[7], 1);
    fetch(8'd5, 32'h00300393, 32'h110);
    step(1);
    chk("s4_read_tag", read_tag, 5);
    wb_rd = 5'd7; wb_tag = 8'd2;
    step(1);
    chk("s4_o_tag_b", o_tag, 5);
    chk("s4_imm", o_imm, 3);
    chk("s4_busy7_set_wins", dut.busy[7], 1);

    // flush while waiting on x7
    fetch(8'd6, 32'h000384B3, 32'h114);
    step(1);
    chk("s5_stalled", o_stall, 1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("s5_flush_idle", o_stall, 0);
    chk("s5_o_tag_held", o_tag, 5);
    chk("s5_read_tag_held", read_tag, 5);
    chk("s5_busy7_kept", dut.busy[7], 1);
    step(1);
    chk("s5_no_replay", read_tag, 5);
    chk("s5_no_restall", o_stall, 0);
    fetch(8'd7, 32'hFFE00513, 32'h118);
    step(1);
    chk("s5_next_read_tag", read_tag, 6);
    step(1);
    chk("s5_next_o_tag", o_tag, 6);
    chk("s5_next_imm", o_imm, 32'hFFFFFFFE);
    chk("s5_next_rd", o_rd, 10);

    // decode table; fetch tags cross 0xFF -> 0x00 at entry 4
    exp_tag = 8'd6;
    for (int i = 0; i < 9; i++) begin
      t = 8'hFC + 8'(i);
      fetch(t, vt[i].ins, 32'h2000 + 32'(i * 4));
      exp_tag = exp_tag + 8'd1;
      wait_tag(exp_tag, ok);
      chk("tbl_issue", {31'd0, ok}, 1);
      chk("tbl_o_tag", o_tag, exp_tag);
      if (vt[i].chk_imm) chk("tbl_imm", o_imm, vt[i].imm);
      chk("tbl_rd", o_rd, vt[i].rd);
      chk("tbl_wr", o_wr, vt[i].wr);
      chk("tbl_ill", o_ill, vt[i].ill);
      chk("tbl_instr", o_instr, vt[i].ins);
      chk("tbl_pc", o_pc, 32'h2000 + 32'(i * 4));
      step(1);
    end

    // run o_tag round to 0xFF then one more issue must wrap to 0x00
    t = 8'h05;
    while (exp_tag != 8'hFF) begin
      fetch(t, 32'h00000013, 32'h3000);
      t = t + 8'd1;
      exp_tag = exp_tag + 8'd1;
      wait_tag(exp_tag, ok);
      if (!ok) begin
        chk("wrap_timeout", o_tag, exp_tag);
        break;
      end
      step(1);
    end
    chk("pre_wrap_o_tag", o_tag, 8'hFF);
    fetch(t, 32'h00000013, 32'h3004);
    wait_tag(8'h00, ok);
    chk("wrap_issue", {31'd0, ok}, 1);
    chk("wrap_o_tag", o_tag, 0);
    chk("wrap_read_tag", read_tag, 0);
    step(1);

    // reset while held in ISSUE discards the instruction
    t = t + 8'd1;
    ex_busy = 1'b1;
    fetch(t, 32'h00900593, 32'h4000);
    step(1);
    chk("rst_mid_read_tag", read_tag, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    ex_busy = 1'b0;
    chk("rst_mid_o_tag", o_tag, 0);
    chk("rst_mid_read_tag0", read_tag, 0);
    chk("rst_mid_busy", dut.busy, 0);
    step(3);
    chk("rst_no_spurious_o_tag", o_tag, 0);
    chk("rst_no_spurious_read", read_tag, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
